// File: rtl/nexys_starship_laser.sv
// Player laser for the Nexys Starship terminals: accepts aimed fire requests, pulses kill at the
// targeted terminal, and tracks energy recharge, post-shot cooldown, score and consecutive misses.
module nexys_starship_laser #(
  parameter int NUM_TERM       = 4,
  parameter int MAX_ENERGY     = 5,
  parameter int RECHARGE_TICKS = 8,
  parameter int COOLDOWN_TICKS = 2,
  parameter int MISS_LIMIT     = 3
) (
  input  logic                timer_clk,
  input  logic                Reset,
  input  logic                play_flag,
  input  logic                gameover_ctrl,
  input  logic [NUM_TERM-1:0] monster_present,
  input  logic                fire_req,
  input  logic [1:0]          fire_dir,
  output logic                fire_ack,
  output logic [NUM_TERM-1:0] kill,
  output logic [2:0]          energy,
  output logic [7:0]          score,
  output logic                laser_gameover,
  output logic                q_Init,
  output logic                q_Ready,
  output logic                q_Fire,
  output logic                q_Cool
);

  localparam int RC_W = (RECHARGE_TICKS > 1) ? $clog2(RECHARGE_TICKS) : 1;
  localparam int CC_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam int MS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [2:0]      EMAX    = 3'(MAX_ENERGY);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECHARGE_TICKS - 1);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(COOLDOWN_TICKS - 1);
  localparam logic [MS_W-1:0] MS_MAX  = MS_W'(MISS_LIMIT);

  typedef enum logic [3:0] {
    S_INIT  = 4'b0001,
    S_READY = 4'b0010,
    S_FIRE  = 4'b0100,
    S_COOL  = 4'b1000
  } state_t;

  state_t                state_r;
  logic [2:0]            energy_r;
  logic [7:0]            score_r;
  logic [MS_W-1:0]       miss_cnt_r;
  logic [RC_W-1:0]       recharge_cnt_r;
  logic [CC_W-1:0]       cool_cnt_r;
  logic                  armed_r;
  logic                  hit_r;
  logic                  fire_ack_r;
  logic [NUM_TERM-1:0]   kill_r;
  logic                  laser_gameover_r;

  logic                  rech_active_s;
  logic                  wrap_s;
  logic                  accept_s;
  logic                  hit_s;
  logic [NUM_TERM-1:0]   kill_s;
  logic [2:0]            energy_nxt_s;
  logic [RC_W-1:0]       recharge_nxt_s;
  logic [MS_W-1:0]       miss_inc_s;
  logic [7:0]            score_inc_s;

  // Next-value logic for energy/recharge, accept decision and aimed-terminal decode
  always_comb begin
    rech_active_s = ((state_r == S_READY) || (state_r == S_FIRE) || (state_r == S_COOL))
                    && (energy_r < EMAX);
    wrap_s        = rech_active_s && (recharge_cnt_r == RC_LAST);
    accept_s      = (state_r == S_READY) && fire_req && armed_r && (energy_r != 3'd0);

    // A wrap landing on an accept cancels out
    case ({wrap_s, accept_s})
      2'b10:   energy_nxt_s = energy_r + 3'd1;
      2'b01:   energy_nxt_s = energy_r - 3'd1;
      default: energy_nxt_s = energy_r;
    endcase

    if (energy_r >= EMAX) begin
      recharge_nxt_s = '0;
    end else if (!rech_active_s) begin
      recharge_nxt_s = recharge_cnt_r;
    end else if (wrap_s) begin
      recharge_nxt_s = '0;
    end else begin
      recharge_nxt_s = recharge_cnt_r + RC_W'(1);
    end

    // Directions past the last terminal decode to nothing, i.e. a miss
    hit_s  = 1'b0;
    kill_s = '0;
    for (int i = 0; i < NUM_TERM; i++) begin
      if (int'(fire_dir) == i) begin
        hit_s     = monster_present[i];
        kill_s[i] = monster_present[i];
      end else begin
        kill_s[i] = 1'b0;
      end
    end

    if (miss_cnt_r == MS_MAX) begin
      miss_inc_s = miss_cnt_r;
    end else begin
      miss_inc_s = miss_cnt_r + MS_W'(1);
    end

    if (score_r == 8'hFF) begin
      score_inc_s = score_r;
    end else begin
      score_inc_s = score_r + 8'd1;
    end
  end

  // Laser control FSM with all counters and registered outputs
  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      state_r          <= S_INIT;
      energy_r         <= EMAX;
      score_r          <= 8'd0;
      miss_cnt_r       <= '0;
      recharge_cnt_r   <= '0;
      cool_cnt_r       <= '0;
      armed_r          <= 1'b1;
      hit_r            <= 1'b0;
      fire_ack_r       <= 1'b0;
      kill_r           <= '0;
      laser_gameover_r <= 1'b0;
    end else begin
      fire_ack_r <= 1'b0;
      kill_r     <= '0;
      if (!fire_req) begin
        armed_r <= 1'b1;
      end
      if (gameover_ctrl) begin
        state_r <= S_INIT;
      end else begin
        energy_r       <= energy_nxt_s;
        recharge_cnt_r <= recharge_nxt_s;
        case (state_r)
          S_INIT: begin
            if (play_flag) begin
              state_r          <= S_READY;
              score_r          <= 8'd0;
              miss_cnt_r       <= '0;
              energy_r         <= EMAX;
              recharge_cnt_r   <= '0;
              armed_r          <= 1'b1;
              laser_gameover_r <= 1'b0;
            end
          end
          S_READY: begin
            // kill/ack are launched here so they are visible during the FIRE cycle
            if (accept_s) begin
              state_r    <= S_FIRE;
              hit_r      <= hit_s;
              kill_r     <= kill_s;
              fire_ack_r <= 1'b1;
              armed_r    <= 1'b0;
            end
          end
          S_FIRE: begin
            state_r    <= S_COOL;
            cool_cnt_r <= '0;
            if (hit_r) begin
              score_r    <= score_inc_s;
              miss_cnt_r <= '0;
            end else begin
              miss_cnt_r <= miss_inc_s;
              if (miss_inc_s == MS_MAX) begin
                laser_gameover_r <= 1'b1;
              end
            end
          end
          S_COOL: begin
            if (cool_cnt_r == CC_LAST) begin
              state_r <= S_READY;
            end else begin
              cool_cnt_r <= cool_cnt_r + CC_W'(1);
            end
          end
          default: begin
            state_r <= S_INIT;
          end
        endcase
      end
    end
  end

  assign fire_ack       = fire_ack_r;
  assign kill           = kill_r;
  assign energy         = energy_r;
  assign score          = score_r;
  assign laser_gameover = laser_gameover_r;
  assign q_Init         = state_r[0];
  assign q_Ready        = state_r[1];
  assign q_Fire         = state_r[2];
  assign q_Cool         = state_r[3];

endmodule

// File: tb/tb_nexys_starship_laser.sv
// Directed bench for nexys_starship_laser; recharge period lengthened so energy drain is visible.
module tb_nexys_starship_laser;

  localparam logic [31:0] ST_INIT  = 32'h8;
  localparam logic [31:0] ST_READY = 32'h4;
  localparam logic [31:0] ST_FIRE  = 32'h2;
  localparam logic [31:0] ST_COOL  = 32'h1;

  logic       timer_clk = 1'b0;
  logic       Reset = 1'b0;
  logic       play_flag = 1'b0;
  logic       gameover_ctrl = 1'b0;
  logic [3:0] monster_present = 4'b0000;
  logic       fire_req = 1'b0;
  logic [1:0] fire_dir = 2'd0;
  logic       fire_ack;
  logic [3:0] kill;
  logic [2:0] energy;
  logic [7:0] score;
  logic       laser_gameover;
  logic       q_Init, q_Ready, q_Fire, q_Cool;
  logic [3:0] flags;

  int n_checks = 0;
  int n_fail   = 0;

  assign flags = {q_Init, q_Ready, q_Fire, q_Cool};

  nexys_starship_laser #(
    .NUM_TERM(4), .MAX_ENERGY(5), .RECHARGE_TICKS(24), .COOLDOWN_TICKS(2), .MISS_LIMIT(3)
  ) dut (
    .timer_clk(timer_clk), .Reset(Reset), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
    .monster_present(monster_present), .fire_req(fire_req), .fire_dir(fire_dir),
    .fire_ack(fire_ack), .kill(kill), .energy(energy), .score(score),
    .laser_gameover(laser_gameover), .q_Init(q_Init), .q_Ready(q_Ready), .q_Fire(q_Fire),
    .q_Cool(q_Cool)
  );

  always #5 timer_clk = ~timer_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge timer_clk);
    #1;
  endtask

  task automatic do_reset();
    play_flag = 1'b0; gameover_ctrl = 1'b0; fire_req = 1'b0; fire_dir = 2'd0;
    monster_present = 4'b0000;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic start_game();
    play_flag = 1'b1;
    tick();
    play_flag = 1'b0;
  endtask

  // Fire at dir (waiting for energy if needed), report kill seen with the ack, return to READY
  task automatic shoot(input logic [1:0] dir, output logic [3:0] kill_seen);
    logic ok;
    ok = 1'b0;
    kill_seen = 4'b0000;
    fire_req = 1'b1;
    fire_dir = dir;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (fire_ack) begin
        ok = 1'b1;
        kill_seen = kill;
      end
    end
    fire_req = 1'b0;
    check_val("shoot_ack_wait", 32'(ok), 32'h1);
    tick();
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1000000 ns, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acks;
    logic [3:0] ks;
    logic [3:0] exp_kill;

    // Reset values and a single held request
    do_reset();
    check_val("rst_flags", 32'(flags), ST_INIT);
    check_val("rst_energy", 32'(energy), 32'd5);
    check_val("rst_score", 32'(score), 32'd0);
    check_val("rst_ack", 32'(fire_ack), 32'd0);
    check_val("rst_kill", 32'(kill), 32'd0);
    check_val("rst_lgo", 32'(laser_gameover), 32'd0);
    monster_present = 4'b0010;
    start_game();
    check_val("a_ready", 32'(flags), ST_READY);
    fire_req = 1'b1; fire_dir = 2'd1;
    tick();
    check_val("a_fire_flags", 32'(flags), ST_FIRE);
    check_val("a_ack", 32'(fire_ack), 32'd1);
    check_val("a_kill", 32'(kill), 32'h2);
    check_val("a_energy", 32'(energy), 32'd4);
    tick();
    check_val("a_cool_flags", 32'(flags), ST_COOL);
    check_val("a_ack_drop", 32'(fire_ack), 32'd0);
    check_val("a_kill_drop", 32'(kill), 32'd0);
    check_val("a_score", 32'(score), 32'd1);
    acks = 0;
    repeat (4) begin
      tick();
      if (fire_ack) acks++;
    end
    check_val("a_no_refire", 32'(acks), 32'd0);
    check_val("a_back_ready", 32'(flags), ST_READY);
    check_val("a_energy_hold", 32'(energy), 32'd4);
    fire_req = 1'b0;
    tick();
    fire_req = 1'b1;
    tick();
    check_val("a_rearm_ack", 32'(fire_ack), 32'd1);
    check_val("a_rearm_energy", 32'(energy), 32'd3);
    fire_req = 1'b0;
    repeat (3) tick();

    // Five back-to-back hits drain energy, sixth waits for recharge
    do_reset();
    monster_present = 4'b1111;
    start_game();
    for (int i = 0; i < 5; i++) begin
      fire_req = 1'b1;
      fire_dir = 2'(i);
      exp_kill = 4'b0001 << fire_dir;
      tick();
      check_val("b_ack", 32'(fire_ack), 32'd1);
      check_val("b_kill", 32'(kill), 32'(exp_kill));
      fire_req = 1'b0;
      repeat (3) tick();
    end
    check_val("b_energy_empty", 32'(energy), 32'd0);
    check_val("b_score5", 32'(score), 32'd5);
    fire_req = 1'b1; fire_dir = 2'd2;
    acks = 0;
    repeat (5) begin
      tick();
      if (fire_ack) acks++;
    end
    check_val("b_pending_noack", 32'(acks), 32'd0);
    check_val("b_recharged", 32'(energy), 32'd1);
    tick();
    check_val("b_pending_ack", 32'(fire_ack), 32'd1);
    check_val("b_pending_kill", 32'(kill), 32'h4);
    check_val("b_energy_after", 32'(energy), 32'd0);
    fire_req = 1'b0;
    repeat (3) tick();

    // Miss counting, reset of the run by a hit, and miss-limit game-over
    do_reset();
    monster_present = 4'b0001;
    start_game();
    shoot(2'd2, ks);
    check_val("c_miss1_kill", 32'(ks), 32'd0);
    shoot(2'd3, ks);
    check_val("c_miss2_lgo", 32'(laser_gameover), 32'd0);
    shoot(2'd0, ks);
    check_val("c_hit_kill", 32'(ks), 32'h1);
    shoot(2'd1, ks);
    shoot(2'd2, ks);
    check_val("c_after_hit_lgo", 32'(laser_gameover), 32'd0);
    shoot(2'd3, ks);
    check_val("c_miss3_kill", 32'(ks), 32'd0);
    check_val("c_limit_lgo", 32'(laser_gameover), 32'd1);
    check_val("c_score", 32'(score), 32'd1);
    gameover_ctrl = 1'b1;
    tick();
    gameover_ctrl = 1'b0;
    check_val("c_init", 32'(flags), ST_INIT);
    start_game();
    check_val("c_lgo_clear", 32'(laser_gameover), 32'd0);
    check_val("c_restart_ready", 32'(flags), ST_READY);

    // gameover_ctrl during FIRE and during COOLDOWN
    do_reset();
    monster_present = 4'b0001;
    start_game();
    shoot(2'd0, ks);
    fire_req = 1'b1; fire_dir = 2'd1;
    tick();
    check_val("d_in_fire", 32'(flags), ST_FIRE);
    gameover_ctrl = 1'b1; fire_req = 1'b0;
    tick();
    check_val("d_fire_go_init", 32'(flags), ST_INIT);
    check_val("d_fire_go_ack", 32'(fire_ack), 32'd0);
    check_val("d_fire_go_kill", 32'(kill), 32'd0);
    check_val("d_fire_go_score", 32'(score), 32'd1);
    gameover_ctrl = 1'b0;
    tick();
    check_val("d_init_hold", 32'(flags), ST_INIT);
    check_val("d_score_hold", 32'(score), 32'd1);
    start_game();
    check_val("d_new_score", 32'(score), 32'd0);
    check_val("d_new_energy", 32'(energy), 32'd5);
    fire_req = 1'b1; fire_dir = 2'd0;
    tick();
    fire_req = 1'b0;
    tick();
    check_val("d_cool_score", 32'(score), 32'd1);
    gameover_ctrl = 1'b1;
    tick();
    gameover_ctrl = 1'b0;
    check_val("d_cool_go_init", 32'(flags), ST_INIT);
    check_val("d_cool_go_score", 32'(score), 32'd1);
    start_game();
    check_val("d_ready2", 32'(flags), ST_READY);
    check_val("d_score0", 32'(score), 32'd0);
    check_val("d_energy5", 32'(energy), 32'd5);

    // Recharge wrap on the same edge as an accept at energy 3
    do_reset();
    monster_present = 4'b0001;
    start_game();
    fire_req = 1'b1; fire_dir = 2'd0;
    tick();
    check_val("e_energy4", 32'(energy), 32'd4);
    fire_req = 1'b0;
    repeat (3) tick();
    fire_req = 1'b1;
    tick();
    check_val("e_energy3", 32'(energy), 32'd3);
    fire_req = 1'b0;
    repeat (19) tick();
    check_val("e_energy3_pre", 32'(energy), 32'd3);
    fire_req = 1'b1;
    tick();
    check_val("e_coinc_ack", 32'(fire_ack), 32'd1);
    check_val("e_coinc_energy", 32'(energy), 32'd3);
    fire_req = 1'b0;
    repeat (3) tick();

    // Score saturation at 255
    do_reset();
    monster_present = 4'b0001;
    start_game();
    for (int i = 0; i < 255; i++) shoot(2'd0, ks);
    check_val("f_score255", 32'(score), 32'd255);
    shoot(2'd0, ks);
    check_val("f_sat_kill", 32'(ks), 32'h1);
    check_val("f_score_sat", 32'(score), 32'd255);

    // Asynchronous reset between edges while cooling down
    do_reset();
    monster_present = 4'b0001;
    start_game();
    fire_req = 1'b1; fire_dir = 2'd0;
    tick();
    fire_req = 1'b0;
    tick();
    check_val("g_cool", 32'(flags), ST_COOL);
    #2;
    Reset = 1'b1;
    #1;
    check_val("g_async_flags", 32'(flags), ST_INIT);
    check_val("g_async_energy", 32'(energy), 32'd5);
    check_val("g_async_score", 32'(score), 32'd0);
    check_val("g_async_ack", 32'(fire_ack), 32'd0);
    check_val("g_async_kill", 32'(kill), 32'd0);
    #2;
    Reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
